// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module   : iter_divider
//  Purpose  : Iterative restoring divider with UDIV/SDIV semantics, one
//             quotient bit per clock, for the execute-stage integer unit.
//  Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    count_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shift_d;
    logic             ge_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    // The shifted partial remainder needs WIDTH+1 bits; after a successful
    // subtract the result is below the divisor, so WIDTH bits hold it exactly.
    assign shift_d = {rem_q, quo_q[WIDTH-1]};
    assign ge_d    = (shift_d >= {1'b0, dvsr_q});
    assign rem_d   = ge_d ? (shift_d[WIDTH-1:0] - dvsr_q) : shift_d[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], ge_d};

    assign quo_fix_d = qneg_q ? -quo_q : quo_q;
    assign rem_fix_d = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            count_q       <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Divide by zero reports the raw dividend as remainder.
                            rem_q   <= dividend;
                            quo_q   <= '0;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            zero_q  <= 1'b1;
                            state_q <= S_FIX;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dvd_mag;
                            dvsr_q  <= dvs_mag;
                            qneg_q  <= dvd_neg ^ dvs_neg;
                            rneg_q  <= dvd_neg;
                            zero_q  <= 1'b0;
                            count_q <= CW'(WIDTH - 1);
                            state_q <= S_CALC;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (count_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                S_FIX: begin
                    quotient_q    <= quo_fix_d;
                    remainder_q   <= rem_fix_d;
                    div_by_zero_q <= zero_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_divider
//  Purpose  : Self-checking bench for iter_divider against a transaction-level
//             arithmetic model, plus directed literal cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '0; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b; z = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // Transaction-level model: an accepted op completes after a fixed latency.
    logic         m_pending = 1'b0;
    int           m_left    = 0;
    logic         m_busy    = 1'b0;
    logic         m_done    = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, m_nq = '0, m_nr = '0;
    logic         m_z = 1'b0, m_nz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            m_pending = 1'b0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
            m_q = '0; m_r = '0; m_z = 1'b0;
        end else begin
            acc    = start && !m_pending;
            m_done = 1'b0;
            if (m_pending) begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 1'b0;
                    m_done    = 1'b1;
                    m_q = m_nq; m_r = m_nr; m_z = m_nz;
                end
            end
            if (acc) begin
                ref_div(dividend, divisor, is_signed, m_nq, m_nr, m_nz);
                m_left    = (divisor == '0) ? 1 : W + 1;
                m_pending = 1'b1;
            end
            m_busy = m_pending;
        end
    end

    always @(negedge clk) begin
        chk("busy",        busy,        m_busy);
        chk("done",        done,        m_done);
        chk("quotient",    quotient,    m_q);
        chk("remainder",   remainder,   m_r);
        chk("div_by_zero", div_by_zero, m_z);
    end

    // Called just after a rising edge; returns with the DONE cycle in progress.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int inj,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z, output int lat);
        logic seen;
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1'b1; start = 1'b0;
            end else if (lat == inj) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (!seen) chk("done_timeout", 32'(lat), 32'(0));
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q, r, eq, er, a, b;
        logic         z, ez, s;
        int           lat, inj, ndone;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        idle(1);

        do_op(32'd100, 32'd7, 1'b0, -1, q, r, z, lat);
        chk("t1_q", q, 32'd14); chk("t1_r", r, 32'd2); chk("t1_z", z, 0); chk("t1_lat", 32'(lat), 32'd33);
        idle(2);

        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, q, r, z, lat);
        chk("t2a_q", q, 32'hFFFF_FFFD); chk("t2a_r", r, 32'hFFFF_FFFF);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, q, r, z, lat);
        chk("t2b_q", q, 32'hFFFF_FFFD); chk("t2b_r", r, 32'd1);
        idle(1);

        do_op(32'h1234_5678, 32'd0, 1'b0, -1, q, r, z, lat);
        chk("t3_q", q, 0); chk("t3_r", r, 32'h1234_5678); chk("t3_z", z, 1); chk("t3_lat", 32'(lat), 32'd1);
        idle(1);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, q, r, z, lat);
        chk("t4a_q", q, 32'h8000_0000); chk("t4a_r", r, 0); chk("t4a_z", z, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, q, r, z, lat);
        chk("t4b_q", q, 32'hFFFF_FFFF); chk("t4b_r", r, 0);
        do_op(32'd5, 32'd9, 1'b0, -1, q, r, z, lat);
        chk("t4c_q", q, 0); chk("t4c_r", r, 32'd5);
        idle(1);

        do_op(32'd1000, 32'd10, 1'b0, 5, q, r, z, lat);
        chk("t5a_q", q, 32'd100); chk("t5a_r", r, 0); chk("t5a_lat", 32'(lat), 32'd33);
        do_op(32'd50, 32'd7, 1'b0, -1, q, r, z, lat);
        chk("t5b_q", q, 32'd7); chk("t5b_r", r, 32'd1); chk("t5b_lat", 32'(lat), 32'd33);
        idle(1);

        is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd11; start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(10);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0); chk("t6_done", done, 0);
        chk("t6_q", quotient, 0); chk("t6_r", remainder, 0); chk("t6_z", div_by_zero, 0);
        idle(2);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t6_no_done", 32'(ndone), 0);
        do_op(32'd9, 32'd3, 1'b0, -1, q, r, z, lat);
        chk("t6_q_after", q, 32'd3); chk("t6_r_after", r, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom; s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2, 3: b = 32'($urandom_range(1, 16));
                4:       b = 32'hFFFF_FFFF;
                5:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                6:       b = a + 32'd1;
                default: b = $urandom;
            endcase
            inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : -1;
            do_op(a, b, s, inj, q, r, z, lat);
            ref_div(a, b, s, eq, er, ez);
            chk("rnd_q", q, eq); chk("rnd_r", r, er); chk("rnd_z", z, ez);
            chk("rnd_lat", 32'(lat), (b == '0) ? 32'd1 : 32'd33);
            idle($urandom_range(0, 3));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
